// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the rv32 pipeline.
//
// Computes the ALU result from the alu_decoder control code and resolves
// branches and jumps. The outcome is held in a one-entry output register
// with a valid/ready handshake toward the memory stage.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   in_valid_i/in_ready_o upstream handshake from decode
//   alu_cont_i            4-bit ALU control code
//   op_a_i, op_b_i        operands (op_b already muxed reg/imm)
//   pc_i, imm_i           instruction PC and sign-extended immediate
//   rd_i, reg_write_i     destination register and write enable
//   branch_i, jump_i,
//   jalr_i                control-flow qualifiers
//   flush_i               kill the held entry and the current input
//   out_valid_o/out_ready_i downstream handshake toward memory stage
//   result_o, rd_o,
//   reg_write_o           registered result and writeback info
//   redirect_o,
//   redirect_pc_o         control-flow redirect (pulse on handoff) + target
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. valid never depends on ready on the same interface. While
// out_valid_o=1 and out_ready_i=0 every output holds stable.
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3:0]           alu_cont_i,
  input  logic [XLEN-1:0]      op_a_i,
  input  logic [XLEN-1:0]      op_b_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  input  logic                 reg_write_i,
  input  logic                 branch_i,
  input  logic                 jump_i,
  input  logic                 jalr_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [RF_ADDR_W-1:0] rd_o,
  output logic                 reg_write_o,
  output logic                 redirect_o,
  output logic [XLEN-1:0]      redirect_pc_o
);

  // alu_decoder control encodings
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_LT   = 4'd3;
  localparam logic [3:0] ALU_LTU  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NEQ  = 4'd11;
  localparam logic [3:0] ALU_GTE  = 4'd12;
  localparam logic [3:0] ALU_GTEU = 4'd13;

  localparam int SHW = $clog2(XLEN);

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, eq;
  logic            is_cmp;
  logic            cmp_flag;
  logic [XLEN-1:0] alu_res;

  assign shamt = op_b_i[SHW-1:0];
  assign lt_s  = $signed(op_a_i) < $signed(op_b_i);
  assign lt_u  = op_a_i < op_b_i;
  assign eq    = op_a_i == op_b_i;

  always_comb begin
    is_cmp   = 1'b0;
    cmp_flag = 1'b0;
    alu_res  = '0;
    case (alu_cont_i)
      ALU_ADD:  alu_res = op_a_i + op_b_i;
      ALU_SUB:  alu_res = op_a_i - op_b_i;
      ALU_SLL:  alu_res = op_a_i << shamt;
      ALU_SRL:  alu_res = op_a_i >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a_i) >>> shamt);
      ALU_XOR:  alu_res = op_a_i ^ op_b_i;
      ALU_OR:   alu_res = op_a_i | op_b_i;
      ALU_AND:  alu_res = op_a_i & op_b_i;
      ALU_LT:   begin is_cmp = 1'b1; cmp_flag = lt_s;  end
      ALU_LTU:  begin is_cmp = 1'b1; cmp_flag = lt_u;  end
      ALU_EQ:   begin is_cmp = 1'b1; cmp_flag = eq;    end
      ALU_NEQ:  begin is_cmp = 1'b1; cmp_flag = ~eq;   end
      ALU_GTE:  begin is_cmp = 1'b1; cmp_flag = ~lt_s; end
      ALU_GTEU: begin is_cmp = 1'b1; cmp_flag = ~lt_u; end
      default:  alu_res = '0;
    endcase
    if (is_cmp) begin
      alu_res = {{(XLEN-1){1'b0}}, cmp_flag};
    end
  end

  // ---------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] result_res;
  logic [XLEN-1:0] target_res;
  logic            taken_res;

  assign pc_plus_imm = pc_i + imm_i;
  assign jalr_sum    = op_a_i + imm_i;

  always_comb begin
    result_res = alu_res;
    target_res = pc_plus_imm;
    taken_res  = 1'b0;
    if (jump_i) begin
      result_res = pc_i + XLEN'(4);
      taken_res  = 1'b1;
      if (jalr_i) begin
        // JALR clears bit 0 of the computed target
        target_res = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
    end else if (branch_i) begin
      result_res = {{(XLEN-1){1'b0}}, cmp_flag};
      taken_res  = cmp_flag;
    end
  end

  // ---------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------
  logic                 valid_q,  valid_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [RF_ADDR_W-1:0] rd_q,     rd_d;
  logic                 rw_q,     rw_d;
  logic                 taken_q,  taken_d;
  logic [XLEN-1:0]      target_q, target_d;
  logic                 accept;

  assign in_ready_o = (~valid_q | out_ready_i) & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    taken_d  = taken_q;
    target_d = target_q;
    if (flush_i) begin
      // flush wins over everything; in_ready_o is already 0 so no accept
      valid_d = 1'b0;
      taken_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = result_res;
      rd_d     = rd_i;
      rw_d     = reg_write_i;
      taken_d  = taken_res;
      target_d = target_res;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign result_o      = result_q;
  assign rd_o          = rd_q;
  assign reg_write_o   = rw_q & valid_q;
  // redirect fires only on the handoff cycle of a taken entry
  assign redirect_o    = taken_q & valid_q & out_ready_i;
  assign redirect_pc_o = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// Directed scenarios from the test plan, then randomized traffic checked
// against a behavioural model with an expected-entry queue.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  localparam int XLEN = 32;
  localparam int RFW  = 5;

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_SLL  = 4'd2;
  localparam logic [3:0] C_LT   = 4'd3;
  localparam logic [3:0] C_LTU  = 4'd4;
  localparam logic [3:0] C_XOR  = 4'd5;
  localparam logic [3:0] C_SRL  = 4'd6;
  localparam logic [3:0] C_SRA  = 4'd7;
  localparam logic [3:0] C_OR   = 4'd8;
  localparam logic [3:0] C_AND  = 4'd9;
  localparam logic [3:0] C_EQ   = 4'd10;
  localparam logic [3:0] C_NEQ  = 4'd11;
  localparam logic [3:0] C_GTE  = 4'd12;
  localparam logic [3:0] C_GTEU = 4'd13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_ready;
  logic [3:0]      alu_cont;
  logic [XLEN-1:0] op_a, op_b, pc, imm;
  logic [RFW-1:0]  rd;
  logic            reg_write, branch, jump, jalr, flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] result;
  logic [RFW-1:0]  rd_out;
  logic            reg_write_out, redirect;
  logic [XLEN-1:0] redirect_pc;

  ex_stage #(.XLEN(XLEN), .RF_ADDR_W(RFW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_cont_i(alu_cont), .op_a_i(op_a), .op_b_i(op_b),
    .pc_i(pc), .imm_i(imm), .rd_i(rd), .reg_write_i(reg_write),
    .branch_i(branch), .jump_i(jump), .jalr_i(jalr), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .rd_o(rd_out), .reg_write_o(reg_write_out),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc)
  );

  int checks = 0;
  int passed = 0;

  // expected entry: {taken, target[31:0], rd[4:0], reg_write, result[31:0]}
  logic [70:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [70:0] model_entry(
    input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] p, input logic [31:0] im, input logic [4:0] d,
    input logic w, input logic br, input logic jmp, input logic jr);
    logic [31:0] r;
    logic [31:0] tgt;
    logic        tk;
    int          sh;
    sh = int'(b % 32);
    case (code)
      C_ADD:  r = a + b;
      C_SUB:  r = a - b;
      C_SLL:  r = a << sh;
      C_SRL:  r = a >> sh;
      C_SRA:  r = $signed(a) >>> sh;
      C_XOR:  r = a ^ b;
      C_OR:   r = a | b;
      C_AND:  r = a & b;
      C_LT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_LTU:  r = (a < b) ? 32'd1 : 32'd0;
      C_EQ:   r = (a == b) ? 32'd1 : 32'd0;
      C_NEQ:  r = (a != b) ? 32'd1 : 32'd0;
      C_GTE:  r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      C_GTEU: r = (a >= b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    tk  = jmp || (br && r == 32'd1);
    tgt = (jmp && jr) ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
    if (jmp) r = p + 32'd4;
    return {tk, tgt, d, w, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p,
                          input logic [31:0] im, input logic [4:0] d,
                          input logic w, input logic br, input logic jmp,
                          input logic jr);
    in_valid = 1'b1; alu_cont = code; op_a = a; op_b = b; pc = p; imm = im;
    rd = d; reg_write = w; branch = br; jump = jmp; jalr = jr;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; alu_cont = C_ADD; op_a = '0; op_b = '0; pc = '0;
    imm = '0; rd = '0; reg_write = 1'b0; branch = 1'b0; jump = 1'b0;
    jalr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive_op(C_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    checks++; if (result !== 32'd0) $display("FAIL reset_result: got %h want 0", result); else passed++;
    checks++; if (rd_out !== 5'd0 || reg_write_out !== 1'b0)
      $display("FAIL reset_rd: got rd=%0d rw=%b want 0/0", rd_out, reg_write_out); else passed++;
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'd0)
      $display("FAIL reset_redirect: got %b/%h want 0/0", redirect, redirect_pc); else passed++;
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive_op(C_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL add_ready0: got %b want 1", in_ready); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd12)
      $display("FAIL add_result: got v=%b r=%0d want 1/12", out_valid, result); else passed++;
    checks++; if (rd_out !== 5'd3 || reg_write_out !== 1'b1 || redirect !== 1'b0)
      $display("FAIL add_wb: got rd=%0d rw=%b redir=%b want 3/1/0", rd_out, reg_write_out, redirect); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL add_ready1: got %b want 1", in_ready); else passed++;
    drive_idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0)
      $display("FAIL add_drain: got v=%b rw=%b want 0/0", out_valid, reg_write_out); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_op(C_SRA, 32'h8000_0010, 32'd4, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'hF800_0001)
      $display("FAIL b2b_sra: got v=%b r=%h want 1/f8000001", out_valid, result); else passed++;
    drive_op(C_SRL, 32'h8000_0010, 32'd4, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'h0800_0001 || rd_out !== 5'd5)
      $display("FAIL b2b_srl: got v=%b r=%h rd=%0d want 1/08000001/5", out_valid, result, rd_out); else passed++;
    drive_op(C_LT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (result !== 32'd1) $display("FAIL cmp_lt: got %h want 1", result); else passed++;
    drive_op(C_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd0)
      $display("FAIL cmp_ltu: got v=%b r=%h want 1/0", out_valid, result); else passed++;
    drive_op(4'd15, 32'h1234, 32'h5678, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (result !== 32'd0) $display("FAIL undef_code: got %h want 0", result); else passed++;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    drive_op(C_EQ, 32'd9, 32'd9, 32'h100, 32'h20, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h120)
      $display("FAIL br_taken: got redir=%b pc=%h want 1/120", redirect, redirect_pc); else passed++;
    checks++; if (result !== 32'd1 || reg_write_out !== 1'b0)
      $display("FAIL br_result: got r=%h rw=%b want 1/0", result, reg_write_out); else passed++;
    drive_op(C_EQ, 32'd9, 32'd8, 32'h100, 32'h20, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || redirect !== 1'b0 || result !== 32'd0)
      $display("FAIL br_not_taken: got v=%b redir=%b r=%h want 1/0/0", out_valid, redirect, result); else passed++;
    drive_idle();
    @(negedge clk);
    checks++; if (redirect !== 1'b0) $display("FAIL br_pulse_end: got %b want 0", redirect); else passed++;
  endtask

  task automatic test_jalr();
    out_ready = 1'b1;
    drive_op(C_ADD, 32'h1001, 32'd0, 32'h200, 32'd4, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (result !== 32'h204 || redirect_pc !== 32'h1004 || redirect !== 1'b1)
      $display("FAIL jalr: got r=%h pc=%h redir=%b want 204/1004/1", result, redirect_pc, redirect); else passed++;
    drive_idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || redirect !== 1'b0)
      $display("FAIL jalr_drain: got v=%b redir=%b want 0/0", out_valid, redirect); else passed++;
  endtask

  task automatic test_hold_flush();
    // held entry is a taken JAL so a stray redirect would be visible
    out_ready = 1'b0;
    drive_op(C_ADD, 32'd0, 32'd0, 32'h40, 32'h10, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'h44)
      $display("FAIL hold_load: got v=%b r=%h want 1/44", out_valid, result); else passed++;
    drive_op(C_ADD, 32'd100, 32'd1, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || redirect !== 1'b0)
        $display("FAIL hold_ready: cycle %0d got rdy=%b redir=%b want 0/0", i, in_ready, redirect); else passed++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || result !== 32'h44 || rd_out !== 5'd7 || redirect_pc !== 32'h50)
        $display("FAIL hold_stable: cycle %0d got v=%b r=%h rd=%0d pc=%h want 1/44/7/50",
                 i, out_valid, result, rd_out, redirect_pc); else passed++;
    end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || redirect !== 1'b0 || reg_write_out !== 1'b0)
      $display("FAIL flush_kill: got v=%b redir=%b rw=%b want 0/0/0", out_valid, redirect, reg_write_out); else passed++;
    flush = 1'b0; drive_idle(); out_ready = 1'b1;
    #1;
    checks++; if (redirect !== 1'b0) $display("FAIL flush_no_redir: got %b want 0", redirect); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_capture: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_op(C_ADD, 32'd20, 32'd22, 32'd0, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 32'd42)
      $display("FAIL rstmid_load: got v=%b r=%0d want 1/42", out_valid, result); else passed++;
    drive_idle(); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0)
      $display("FAIL rstmid_drop: got v=%b r=%h rd=%0d want 0/0/0", out_valid, result, rd_out); else passed++;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0]  cmp_codes [6];
    logic [70:0] e;
    logic        exp_ready, exp_redir;
    int          kind;
    cmp_codes[0] = C_LT; cmp_codes[1] = C_LTU; cmp_codes[2] = C_EQ;
    cmp_codes[3] = C_NEQ; cmp_codes[4] = C_GTE; cmp_codes[5] = C_GTEU;
    exp_q.delete();
    drive_idle(); out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== (exp_q.size() != 0))
        $display("FAIL rnd_valid: iter %0d got %b want %b", i, out_valid, exp_q.size() != 0); else passed++;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        checks++; if (result !== e[31:0] || rd_out !== e[37:33] || reg_write_out !== e[32])
          $display("FAIL rnd_data: iter %0d got r=%h rd=%0d rw=%b want %h/%0d/%b",
                   i, result, rd_out, reg_write_out, e[31:0], e[37:33], e[32]); else passed++;
        if (e[70]) begin
          checks++; if (redirect_pc !== e[69:38])
            $display("FAIL rnd_target: iter %0d got %h want %h", i, redirect_pc, e[69:38]); else passed++;
        end
      end else begin
        checks++; if (reg_write_out !== 1'b0)
          $display("FAIL rnd_rw_idle: iter %0d got %b want 0", i, reg_write_out); else passed++;
      end
      // new stimulus
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      kind      = $urandom_range(0, 5);
      drive_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
               32'($signed(12'($urandom))), 5'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) op_b = op_a;
      if ($urandom_range(0, 1) == 0) op_b = op_b & 32'h1F;
      if (kind == 4) begin
        alu_cont = cmp_codes[$urandom_range(0, 5)]; branch = 1'b1; reg_write = 1'b0;
      end else if (kind == 5) begin
        jump = 1'b1; jalr = 1'($urandom);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = ((exp_q.size() == 0) || out_ready) && !flush;
      exp_redir = (exp_q.size() != 0) && exp_q[0][70] && out_ready;
      checks++; if (in_ready !== exp_ready)
        $display("FAIL rnd_ready: iter %0d got %b want %b", i, in_ready, exp_ready); else passed++;
      checks++; if (redirect !== exp_redir)
        $display("FAIL rnd_redirect: iter %0d got %b want %b", i, redirect, exp_redir); else passed++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_ready)
          exp_q.push_back(model_entry(alu_cont, op_a, op_b, pc, imm, rd, reg_write,
                                      branch, jump, jalr));
      end
    end
    flush = 1'b0; drive_idle(); out_ready = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_jalr();
    test_hold_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
